// File: rtl/clk_period_meter.sv
// clk_period_meter: single-shot period/high-time measurement of an async clock in clk_in cycles
// Ports:
//   clk_in    - system clock, all logic on its rising edge
//   reset_n   - asynchronous active-low reset
//   clk_meas  - asynchronous signal under measurement
//   start     - one-cycle measurement request, honoured only in IDLE
//   busy      - high while a measurement is in progress
//   done      - one-cycle pulse when the result registers are updated
//   period    - clk_in cycles between two consecutive rising edges of clk_meas
//   high_time - clk_in cycles from that rising edge to the following falling edge
//   timeout   - last measurement aborted because clk_meas never completed a period
module clk_period_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             clk_meas,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
  localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] hi_sh_q, hi_sh_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic timeout_q, timeout_d;
  logic meas, rise, fall, expire;
  assign meas   = sync_q[SYNC_STAGES-1];
  assign rise   = meas & ~prev_q;
  assign fall   = ~meas & prev_q;
  assign expire = tmr_q == TMR_LAST;
  assign period    = period_q;
  assign high_time = high_q;
  assign timeout   = timeout_q;
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      hi_sh_q   <= '0;
      period_q  <= '0;
      high_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], clk_meas};
      prev_q    <= meas;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      hi_sh_q   <= hi_sh_d;
      period_q  <= period_d;
      high_q    <= high_d;
      timeout_q <= timeout_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    hi_sh_d   = hi_sh_q;
    period_d  = period_q;
    high_d    = high_q;
    timeout_d = timeout_q;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          tmr_d   = '0;
        end
      end
      ARM: begin
        busy  = 1'b1;
        tmr_d = tmr_q + ONE;
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = ONE;
          hi_sh_d = '0;
        end
        // a rise here only opens the window, so expiry still wins
        if (expire) begin
          state_d   = DONE;
          period_d  = '0;
          high_d    = '0;
          timeout_d = 1'b1;
        end
      end
      MEASURE: begin
        busy  = 1'b1;
        tmr_d = tmr_q + ONE;
        cnt_d = cnt_q + ONE;
        // cnt is at least 1 here, so a zero shadow means no fall seen yet
        if (fall && hi_sh_q == '0)
          hi_sh_d = cnt_q;
        if (rise) begin
          state_d   = DONE;
          period_d  = cnt_q;
          high_d    = hi_sh_q;
          timeout_d = 1'b0;
        end else if (expire) begin
          state_d   = DONE;
          period_d  = '0;
          high_d    = '0;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: randomized and directed checks of clk_period_meter against a waveform-level model
module tb_clk_period_meter;
  localparam int S  = 2;
  localparam int NW = 20000;
  logic clk = 1'b0, reset_n = 1'b0, clk_meas = 1'b0, start = 1'b0;
  logic busy_a, done_a, to_a, busy_b, done_b, to_b;
  logic [31:0] per_a, hi_a, per_b, hi_b;
  bit w [NW];
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  bit run = 1'b0;
  int tc [2] = '{100, 30};
  bit act [2];
  int a_c [2], d_c [2], pp [2], ph [2];
  bit pt [2];
  bit eb [2], ed [2], et [2];
  int ep [2], eh [2];
  always #5 clk = ~clk;
  clk_period_meter #(.CNT_W(32), .TIMEOUT_CYC(100), .SYNC_STAGES(S)) dut_a (
    .clk_in(clk), .reset_n(reset_n), .clk_meas(clk_meas), .start(start),
    .busy(busy_a), .done(done_a), .period(per_a), .high_time(hi_a), .timeout(to_a));
  clk_period_meter #(.CNT_W(32), .TIMEOUT_CYC(30), .SYNC_STAGES(S)) dut_b (
    .clk_in(clk), .reset_n(reset_n), .clk_meas(clk_meas), .start(start),
    .busy(busy_b), .done(done_b), .period(per_b), .high_time(hi_b), .timeout(to_b));
  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act_v, exp_v, cyc);
    end
  endtask
  // level seen by the edge detector in cycle j: clk_meas sampled S-1 edges earlier
  function automatic bit lv(input int j);
    return (j - S + 1 >= 0 && j - S + 1 < NW) ? w[j-S+1] : 1'b0;
  endfunction
  function automatic bit is_rise(input int j);
    return lv(j) && !lv(j-1);
  endfunction
  function automatic bit is_fall(input int j);
    return !lv(j) && lv(j-1);
  endfunction
  // outcome of a measurement accepted at edge a: search the planned waveform for two rises inside the window
  function automatic void predict(input int a, input int tcy, output int d, output int per, output int hi, output bit to);
    int r, r2, f;
    r = -1; r2 = -1; f = -1;
    for (int j = a; j < a + tcy; j++) begin
      if (r < 0) begin
        if (is_rise(j)) r = j;
      end else if (is_rise(j)) begin
        r2 = j;
        break;
      end else if (f < 0 && is_fall(j)) f = j;
    end
    if (r2 >= 0) begin
      d = r2 + 1; per = r2 - r; hi = (f < 0) ? 0 : f - r; to = 1'b0;
    end else begin
      d = a + tcy; per = 0; hi = 0; to = 1'b1;
    end
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 1'b0; eb[i] = 1'b0; ed[i] = 1'b0; et[i] = 1'b0; ep[i] = 0; eh[i] = 0;
      end
    end else begin
      int k;
      k = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (start && (!act[i] || k - 1 > d_c[i])) begin
          predict(k, tc[i], d_c[i], pp[i], ph[i], pt[i]);
          act[i] = 1'b1;
          a_c[i] = k;
        end
        if (act[i] && k == d_c[i]) begin
          ep[i] = pp[i]; eh[i] = ph[i]; et[i] = pt[i];
        end
        eb[i] = act[i] && k >= a_c[i] && k < d_c[i];
        ed[i] = act[i] && k == d_c[i];
      end
    end
  end
  always @(negedge clk) begin
    if (run) begin
      chk("busy_a", busy_a, eb[0]);
      chk("done_a", done_a, ed[0]);
      chk("period_a", per_a, ep[0]);
      chk("high_a", hi_a, eh[0]);
      chk("timeout_a", to_a, et[0]);
      chk("busy_b", busy_b, eb[1]);
      chk("done_b", done_b, ed[1]);
      chk("period_b", per_b, ep[1]);
      chk("high_b", hi_b, eh[1]);
      chk("timeout_b", to_b, et[1]);
    end
  end
  initial forever begin
    @(negedge clk);
    clk_meas = (cyc + 1 < NW) ? w[cyc+1] : 1'b0;
  end
  task automatic plan(input int from, input int hi, input int lo, input int len);
    for (int j = 0; j < len; j++)
      if (from + j < NW) w[from+j] = (j % (hi + lo)) < hi;
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input bit b, input int maxc, output int n);
    n = 0;
    while (!(b ? done_b : done_a) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(b ? "wait_done_b" : "wait_done_a", b ? done_b : done_a, 1);
  endtask
  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int n, nd;
    tick(3);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_period", per_a, 0);
    chk("rst_high", hi_a, 0);
    chk("rst_timeout", to_a, 0);
    #1 reset_n = 1'b1;
    run = 1'b1;
    tick(2);
    plan(cyc + 2, 5, 5, 400);
    tick(20);
    pulse();
    chk("t1_busy", busy_a, 1);
    wait_done(1'b0, 200, n);
    chk("t1_period", per_a, 10);
    chk("t1_high", hi_a, 5);
    chk("t1_timeout", to_a, 0);
    chk("t1_busy_in_done", busy_a, 0);
    tick(5);
    plan(cyc + 2, 3, 7, 400);
    tick(20);
    pulse();
    chk("t2_busy", busy_a, 1);
    tick(1);
    pulse();
    tick(4);
    pulse();
    wait_done(1'b0, 200, n);
    chk("t2_period", per_a, 10);
    chk("t2_high", hi_a, 3);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      nd += int'(done_a);
    end
    chk("t4_extra_done", nd, 0);
    plan(cyc + 2, 20, 20, 400);
    tick(5);
    pulse();
    tick(30);
    chk("t2_hold_period", per_a, 10);
    chk("t2_hold_high", hi_a, 3);
    wait_done(1'b0, 200, n);
    chk("t2b_period", per_a, 40);
    chk("t2b_high", hi_a, 20);
    tick(5);
    plan(cyc + 2, 0, 1, 400);
    tick(10);
    pulse();
    wait_done(1'b0, 150, n);
    chk("t3_latency", n, 100);
    chk("t3_timeout", to_a, 1);
    chk("t3_period", per_a, 0);
    chk("t3_high", hi_a, 0);
    tick(3);
    plan(cyc + 2, 5, 5, 400);
    tick(20);
    pulse();
    wait_done(1'b0, 200, n);
    chk("t3b_timeout", to_a, 0);
    chk("t3b_period", per_a, 10);
    tick(5);
    plan(cyc + 2, 20, 20, 400);
    tick(5);
    pulse();
    tick(45);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_busy", busy_a, 0);
    chk("t5_done", done_a, 0);
    chk("t5_period", per_a, 0);
    chk("t5_high", hi_a, 0);
    chk("t5_timeout", to_a, 0);
    chk("t5_busy_b", busy_b, 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    plan(cyc + 2, 0, 1, 20);
    plan(cyc + 22, 20, 20, 400);
    tick(30);
    pulse();
    wait_done(1'b0, 200, n);
    chk("t5b_period", per_a, 40);
    chk("t5b_high", hi_a, 20);
    tick(5);
    for (int sh = 0; sh < 2; sh++) begin
      plan(cyc + 2, 0, 1, 8);
      plan(cyc + 9, 10, 19, 400);
      tick(9 - sh);
      pulse();
      wait_done(1'b1, 100, n);
      chk(sh ? "t6_late_timeout" : "t6_timeout", to_b, sh);
      chk(sh ? "t6_late_period" : "t6_period", per_b, sh ? 0 : 29);
      chk(sh ? "t6_late_high" : "t6_high", hi_b, sh ? 0 : 10);
      tick(120);
    end
    for (int it = 0; it < 20; it++) begin
      int hi, lo;
      hi = $urandom_range(1, 30);
      lo = $urandom_range(1, 30);
      if ($urandom_range(0, 7) == 0) begin
        hi = 0;
        lo = 1;
      end
      plan(cyc + 2, hi, lo, 400);
      repeat (250) begin
        start = ($urandom_range(0, 9) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      tick(150);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
